// File: rtl/render_frame_driver.sv
// Raster-order coordinate issuer for the pixel renderer plus frame-buffer write-back of returned pixels.
// Latency: requests valid the cycle after start; an accepted pixel is written one cycle later.
// Backpressure: issue holds on either tready low or credit exhaustion; pixel tready follows ~fb_stall.
module render_frame_driver #(
    parameter int H_ACTIVE        = 320,
    parameter int V_ACTIVE        = 180,
    parameter int ADDR_W          = 16,
    parameter int MAX_OUTSTANDING = 512,
    parameter int CNT_W           = 10
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic [10:0]       hcount_axis_tdata,
    output logic              hcount_axis_tvalid,
    input  logic              hcount_axis_tready,
    output logic [9:0]        vcount_axis_tdata,
    output logic              vcount_axis_tvalid,
    input  logic              vcount_axis_tready,
    input  logic [23:0]       pixel_axis_tdata,
    input  logic              pixel_axis_tvalid,
    output logic              pixel_axis_tready,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              fb_stall,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_data,
    output logic              fb_we,
    output logic              coord_error,
    output logic [CNT_W-1:0]  outstanding
);

    localparam int TOTAL = H_ACTIVE * V_ACTIVE;
    localparam int RX_W  = $clog2(TOTAL + 1);

    localparam logic [10:0]       H_LIM   = 11'(H_ACTIVE);
    localparam logic [10:0]       H_LAST  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]        V_LIM   = 10'(V_ACTIVE);
    localparam logic [9:0]        V_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [RX_W-1:0]   RX_LAST = RX_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] H_MUL   = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
    } coord_t;

    state_t            state_q;
    state_t            state_d;
    coord_t            ptr_q;
    logic [RX_W-1:0]   rx_cnt_q;
    logic [CNT_W-1:0]  out_q;

    logic              req_vld;
    logic              req_fire;
    logic              pix_acc;
    logic              pix_act;
    logic              coord_bad;
    logic              ptr_last;
    logic              rx_last;
    logic              frame_start;
    logic [ADDR_W-1:0] addr_calc;

    // Handshake and decode terms shared by the FSM and the datapath
    always_comb begin
        req_vld     = (state_q == ST_ISSUE) && (out_q < MAX_CNT);
        req_fire    = req_vld && hcount_axis_tready && vcount_axis_tready;
        pix_acc     = pixel_axis_tvalid && !fb_stall;
        pix_act     = pix_acc && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
        coord_bad   = (hcount_in >= H_LIM) || (vcount_in >= V_LIM);
        ptr_last    = (ptr_q.h == H_LAST) && (ptr_q.v == V_LAST);
        rx_last     = pix_act && (rx_cnt_q == RX_LAST);
        frame_start = (state_q == ST_IDLE) && start;
        addr_calc   = ADDR_W'(vcount_in) * H_MUL + ADDR_W'(hcount_in);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Completion wins over the ISSUE->DRAIN step when the last return lands with the last issue
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (rx_last)                    state_d = ST_DONE;
                else if (req_fire && ptr_last)  state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (rx_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy               = (state_q != ST_IDLE);
        frame_done         = (state_q == ST_DONE);
        hcount_axis_tvalid = req_vld;
        vcount_axis_tvalid = req_vld;
        hcount_axis_tdata  = ptr_q.h;
        vcount_axis_tdata  = ptr_q.v;
        pixel_axis_tready  = !fb_stall;
        outstanding        = out_q;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ptr_q       <= '0;
            rx_cnt_q    <= '0;
            out_q       <= '0;
            coord_error <= 1'b0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
        end else begin
            fb_we <= 1'b0;
            if (frame_start) begin
                ptr_q       <= '0;
                rx_cnt_q    <= '0;
                out_q       <= '0;
                coord_error <= 1'b0;
            end else begin
                if (req_fire) begin
                    if (ptr_q.h == H_LAST) begin
                        ptr_q.h <= '0;
                        ptr_q.v <= ptr_q.v + 10'd1;
                    end else begin
                        ptr_q.h <= ptr_q.h + 11'd1;
                    end
                end
                // Out-of-range returns still count and release their credit, but never write
                if (pix_act) begin
                    rx_cnt_q <= rx_cnt_q + RX_W'(1);
                    if (coord_bad) begin
                        coord_error <= 1'b1;
                    end else begin
                        fb_we   <= 1'b1;
                        fb_addr <= addr_calc;
                        fb_data <= pixel_axis_tdata;
                    end
                end
                unique case ({req_fire, pix_act})
                    2'b10: out_q <= out_q + CNT_W'(1);
                    2'b01: if (out_q != '0) out_q <= out_q - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_render_frame_driver.sv
// Randomized bench for render_frame_driver: fixed-latency renderer model plus a frame-level reference model.
module tb_render_frame_driver;

    localparam int H     = 4;
    localparam int V     = 3;
    localparam int AW    = 4;
    localparam int MAXO  = 4;
    localparam int CW    = 3;
    localparam int TOTAL = H * V;

    logic          aclk;
    logic          areset;
    logic          start;
    logic          busy;
    logic          frame_done;
    logic [10:0]   hcount_axis_tdata;
    logic          hcount_axis_tvalid;
    logic          hcount_axis_tready;
    logic [9:0]    vcount_axis_tdata;
    logic          vcount_axis_tvalid;
    logic          vcount_axis_tready;
    logic [23:0]   pixel_axis_tdata;
    logic          pixel_axis_tvalid;
    logic          pixel_axis_tready;
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic          fb_stall;
    logic [AW-1:0] fb_addr;
    logic [23:0]   fb_data;
    logic          fb_we;
    logic          coord_error;
    logic [CW-1:0] outstanding;

    render_frame_driver #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .MAX_OUTSTANDING(MAXO), .CNT_W(CW)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start), .busy(busy), .frame_done(frame_done),
        .hcount_axis_tdata(hcount_axis_tdata), .hcount_axis_tvalid(hcount_axis_tvalid),
        .hcount_axis_tready(hcount_axis_tready),
        .vcount_axis_tdata(vcount_axis_tdata), .vcount_axis_tvalid(vcount_axis_tvalid),
        .vcount_axis_tready(vcount_axis_tready),
        .pixel_axis_tdata(pixel_axis_tdata), .pixel_axis_tvalid(pixel_axis_tvalid),
        .pixel_axis_tready(pixel_axis_tready),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .fb_stall(fb_stall),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
        .coord_error(coord_error), .outstanding(outstanding)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int          h;
        int          v;
        int          due;
        logic [23:0] d;
    } rq_t;

    rq_t rq[$];
    int  iss_h[$];
    int  iss_v[$];

    // Reference model: phase 0 idle, 1 issuing, 2 draining, 3 done
    int          m_phase, m_issued, m_recv, m_out;
    bit          m_err, m_we;
    logic [AW-1:0] m_addr;
    logic [23:0] m_data;

    int  n_total, n_bad, cyc, frame_no;
    int  lat, rdy_low_cnt, stall_cnt;
    bit  rnd_rdy, rnd_stall, rnd_start, inject_req, rst_req, start_req;
    int  done_pulses, wr_total, peak_out, discards;
    int  wr_cnt[16];
    logic [23:0] wr_dat[16];

    function automatic logic [23:0] pix(input int h, input int v);
        return {8'(h * 29 + 3), 8'(v * 7 + 1), 8'((h * 16 + v) ^ 8'h5a)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s frame=%0d cyc=%0d: got %0d expected %0d", nm, frame_no, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_issued = 0; m_recv = 0; m_out = 0;
        m_err = 0; m_we = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic step();
        bit hr, vr, acc, iss, bad, exp_vld;
        @(negedge aclk);
        areset = rst_req;
        start  = start_req || (rnd_start && m_phase != 0 && $urandom_range(0, 7) == 0);
        if (rdy_low_cnt > 0) begin
            hr = 0; vr = 0; rdy_low_cnt--;
        end else if (rnd_rdy) begin
            hr = ($urandom_range(0, 3) != 0);
            vr = ($urandom_range(0, 3) != 0);
        end else begin
            hr = 1; vr = 1;
        end
        hcount_axis_tready = hr;
        vcount_axis_tready = vr;
        fb_stall = (stall_cnt > 0) || (rnd_stall && $urandom_range(0, 5) == 0);
        if (stall_cnt > 0) stall_cnt--;
        if (inject_req) begin
            rq.push_front('{h: 7, v: 1, due: cyc, d: 24'hbadbad});
            inject_req = 0;
        end
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            pixel_axis_tvalid = 1'b1;
            hcount_in         = 11'(rq[0].h);
            vcount_in         = 10'(rq[0].v);
            pixel_axis_tdata  = rq[0].d;
        end else begin
            pixel_axis_tvalid = 1'b0;
            hcount_in         = 11'($urandom);
            vcount_in         = 10'($urandom);
            pixel_axis_tdata  = 24'($urandom);
        end
        #1;
        exp_vld = (m_phase == 1) && (m_out < MAXO);
        chk("busy", int'(busy), int'(m_phase != 0));
        chk("frame_done", int'(frame_done), int'(m_phase == 3));
        chk("h_tvalid", int'(hcount_axis_tvalid), int'(exp_vld));
        chk("v_tvalid", int'(vcount_axis_tvalid), int'(exp_vld));
        if (exp_vld) begin
            chk("h_tdata", int'(hcount_axis_tdata), m_issued % H);
            chk("v_tdata", int'(vcount_axis_tdata), m_issued / H);
        end
        chk("pix_tready", int'(pixel_axis_tready), int'(!fb_stall));
        chk("fb_we", int'(fb_we), int'(m_we));
        if (m_we) begin
            chk("fb_addr", int'(fb_addr), int'(m_addr));
            chk("fb_data", int'(fb_data), int'(m_data));
        end
        chk("coord_error", int'(coord_error), int'(m_err));
        chk("outstanding", int'(outstanding), m_out);

        if (frame_done) done_pulses++;
        if (fb_we) begin
            wr_total++;
            wr_cnt[fb_addr]++;
            wr_dat[fb_addr] = fb_data;
        end
        if (int'(outstanding) > peak_out) peak_out = int'(outstanding);
        if (hcount_axis_tvalid && hr && vr) begin
            rq.push_back('{h: int'(hcount_axis_tdata), v: int'(vcount_axis_tdata), due: cyc + lat,
                           d: pix(int'(hcount_axis_tdata), int'(vcount_axis_tdata))});
            iss_h.push_back(int'(hcount_axis_tdata));
            iss_v.push_back(int'(vcount_axis_tdata));
        end
        if (pixel_axis_tvalid && pixel_axis_tready) begin
            if (m_phase == 0) discards++;
            rq.delete(0);
        end

        acc = pixel_axis_tvalid && !fb_stall;
        iss = exp_vld && hr && vr;
        bad = (int'(hcount_in) >= H) || (int'(vcount_in) >= V);
        if (rst_req) begin
            model_reset();
        end else begin
            m_we = 0;
            case (m_phase)
                0: if (start) begin
                       m_phase = 1; m_issued = 0; m_recv = 0; m_out = 0; m_err = 0;
                   end
                3: m_phase = 0;
                default: begin
                    if (iss) m_issued++;
                    if (iss && !acc) m_out++;
                    else if (acc && !iss && m_out > 0) m_out--;
                    if (acc) begin
                        m_recv++;
                        if (bad) m_err = 1;
                        else begin
                            m_we   = 1;
                            m_addr = AW'(int'(vcount_in) * H + int'(hcount_in));
                            m_data = pixel_axis_tdata;
                        end
                    end
                    if (m_recv == TOTAL) m_phase = 3;
                    else if (m_phase == 1 && m_issued == TOTAL) m_phase = 2;
                end
            endcase
        end
        cyc++;
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_h_tvalid", int'(hcount_axis_tvalid), 0);
        chk("rst_v_tvalid", int'(vcount_axis_tvalid), 0);
        chk("rst_h_tdata", int'(hcount_axis_tdata), 0);
        chk("rst_v_tdata", int'(vcount_axis_tdata), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        chk("rst_fb_data", int'(fb_data), 0);
        chk("rst_coord_error", int'(coord_error), 0);
        chk("rst_outstanding", int'(outstanding), 0);
    endtask

    task automatic settle();
        for (int i = 0; i < 300 && rq.size() > 0; i++) step();
        chk("renderer_flushed", rq.size(), 0);
        step();
        step();
    endtask

    // mode 1 plain, 2 tready hold on (1,0), 3 fb_stall burst, 4 bad-coordinate injection, 5 reset in DRAIN
    task automatic run_frame(input int mode, input int budget);
        bit finished, hook_done;
        finished = 0; hook_done = 0;
        frame_no++;
        for (int a = 0; a < 16; a++) begin wr_cnt[a] = 0; wr_dat[a] = '0; end
        iss_h.delete(); iss_v.delete();
        done_pulses = 0; wr_total = 0; peak_out = 0; discards = 0;
        start_req = 1; step(); start_req = 0;
        for (int i = 0; i < budget && !finished; i++) begin
            if (!hook_done) begin
                if (mode == 2 && m_phase == 1 && m_issued == 1) begin
                    rdy_low_cnt = 3; hook_done = 1;
                end else if (mode == 3 && m_recv == 4) begin
                    stall_cnt = 5; hook_done = 1;
                end else if (mode == 4 && m_issued >= 6 && rq.size() > 0) begin
                    inject_req = 1; hook_done = 1;
                end else if (mode == 5 && m_phase == 2 && rq.size() == 3) begin
                    stall_cnt = 1; rst_req = 1; step(); rst_req = 0;
                    step();
                    chk_reset_vals();
                    hook_done = 1; finished = 1;
                end
            end
            if (!finished) begin
                step();
                if (done_pulses > 0 && m_phase == 0) finished = 1;
            end
        end
        chk("frame_complete", int'(finished), 1);
        step();
        if (mode != 5) begin
            chk("done_pulses", done_pulses, 1);
            chk("end_busy", int'(busy), 0);
            chk("end_outstanding", int'(outstanding), 0);
        end
    endtask

    task automatic check_full_frame();
        chk("issue_count", iss_h.size(), TOTAL);
        for (int i = 0; i < iss_h.size() && i < TOTAL; i++) begin
            chk("issue_h", iss_h[i], i % H);
            chk("issue_v", iss_v[i], i / H);
        end
        chk("write_count", wr_total, TOTAL);
        for (int a = 0; a < TOTAL; a++) begin
            chk("write_once", wr_cnt[a], 1);
            chk("write_data", int'(wr_dat[a]), int'(pix(a % H, a / H)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lit_h[12] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
        int lit_v[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
        n_total = 0; n_bad = 0; cyc = 0; frame_no = 0;
        lat = 5; rdy_low_cnt = 0; stall_cnt = 0;
        rnd_rdy = 0; rnd_stall = 0; rnd_start = 0; inject_req = 0; start_req = 0;
        areset = 1'b1; rst_req = 1; start = 1'b0;
        hcount_axis_tready = 1'b1; vcount_axis_tready = 1'b1;
        pixel_axis_tvalid = 1'b0; pixel_axis_tdata = '0;
        hcount_in = '0; vcount_in = '0; fb_stall = 1'b0;
        model_reset();
        repeat (3) step();
        rst_req = 0;
        step();
        chk_reset_vals();

        lat = 5;
        run_frame(1, 1000);
        check_full_frame();
        if (iss_h.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                chk("lit_issue_h", iss_h[i], lit_h[i]);
                chk("lit_issue_v", iss_v[i], lit_v[i]);
            end
        end
        chk("lit_data_addr5", int'(wr_dat[5]), int'(24'h20084b));
        chk("lit_data_addr11", int'(wr_dat[11]), int'(24'h5a0f68));
        settle();

        lat = 20;
        run_frame(1, 1000);
        check_full_frame();
        chk("peak_outstanding", peak_out, 4);
        settle();

        lat = 5;
        run_frame(2, 1000);
        check_full_frame();
        settle();

        run_frame(3, 1000);
        check_full_frame();
        settle();

        run_frame(4, 1000);
        chk("coord_error_sticky", int'(coord_error), 1);
        chk("bad_frame_writes", wr_total, TOTAL - 1);
        settle();
        chk("coord_error_held_idle", int'(coord_error), 1);

        lat = 20;
        run_frame(5, 1000);
        wr_total = 0;
        settle();
        chk("late_discards", discards, 3);
        chk("late_writes", wr_total, 0);
        lat = 5;
        run_frame(1, 1000);
        check_full_frame();
        chk("clean_coord_error", int'(coord_error), 0);
        settle();

        rnd_rdy = 1; rnd_stall = 1; rnd_start = 1;
        for (int f = 0; f < 8; f++) begin
            lat = $urandom_range(1, 25);
            run_frame(1, 2000);
            check_full_frame();
            settle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
